pong_motion_ctrl: RTL and testbench
===================================

# pong_motion_ctrl

Frame-rate game controller for the Pong display. Once per video frame it moves the ball and both paddles, resolves wall and paddle bounces, detects missed balls, keeps score and sequences serve, pause and game-over. Its registered position outputs drive the `x_location`/`y_location` inputs of the per-object box renderers in the VGA pixel path.

## Interface
Parameters:
- `SCREEN_W`, 640: active width, pixels
- `SCREEN_H`, 480: active height, pixels
- `BALL_SIZE`, 8: ball is a square of this side
- `PADDLE_W`, 8: paddle width
- `PADDLE_H`, 64: paddle height
- `PADDLE_L_X`, 16: left paddle left edge
- `PADDLE_R_X`, 616: right paddle left edge
- `BALL_SPEED`, 2: ball step per frame on each axis
- `PADDLE_SPEED`, 4: paddle step per frame
- `PAUSE_FRAMES`, 60: frames held after a point
- `WIN_SCORE`, 9: score that ends the game

Ports:
- `pixel_clk`, in, 1: the only clock
- `rst_n`, in, 1: asynchronous, active-low reset
- `frame_tick`, in, 1: one-cycle pulse per frame, issued at vertical blank start
- `serve`, in, 1: level; starts play or restarts the game
- `btn_l_up`, `btn_l_dn`, `btn_r_up`, `btn_r_dn`, in, 1 each: paddle controls, already synchronised
- `ball_x`, `ball_y`, out, 10 each: ball top-left corner
- `paddle_l_y`, `paddle_r_y`, out, 10 each: paddle top edges
- `score_l`, `score_r`, out, 4 each: points won
- `game_state`, out, 2: 0 IDLE, 1 PLAY, 2 SCORED, 3 OVER
- `point`, out, 1: one-cycle pulse when a point is awarded

## Operation
- Reset values:
  - ball at (316, 236)
  - paddles at 208
  - scores 0
  - IDLE state
  - ball direction right and down
  - `point` low, pause counter 0
- All position, score and state updates happen only in the cycle where `frame_tick` is high. The only exceptions are the IDLE→PLAY and OVER→IDLE transitions on `serve`, which occur in any cycle.
- Paddles:
  - Up subtracts `PADDLE_SPEED` and down adds it.
  - If both or neither button is pressed, the paddle holds.
  - The result clamps to 0..`SCREEN_H-PADDLE_H`, which is 416.
  - Paddles move in IDLE, PLAY and SCORED. They are frozen in OVER.
- Ball moves only in PLAY, by ±`BALL_SPEED` on each axis according to two direction flags.
- Vertical bounce:
  - Moving up with `ball_y <= BALL_SPEED`: `ball_y` becomes 0 and the y-direction flips.
  - Moving down with `ball_y + BALL_SIZE + BALL_SPEED >= SCREEN_H`: `ball_y` becomes 472 and the y-direction flips.
- Paddle hit, left side:
  - Condition: moving left, `ball_x - BALL_SPEED <= PADDLE_L_X + PADDLE_W`, and vertical overlap (`ball_y + BALL_SIZE > paddle_l_y` and `ball_y < paddle_l_y + PADDLE_H`), evaluated on pre-update values.
  - Result: `ball_x` becomes 24 and the direction becomes right.
  - The right side mirrors this. Hit when `ball_x + BALL_SIZE + BALL_SPEED >= PADDLE_R_X` with overlap; `ball_x` becomes 608 and the direction becomes left.
- Miss:
  - Moving left with `ball_x <= BALL_SPEED` and no left hit: `score_r` increments, `point` pulses, state goes to SCORED and the ball freezes.
  - The right side is symmetric at `ball_x + BALL_SIZE + BALL_SPEED >= SCREEN_W`, incrementing `score_l`.
- The paddle-hit check has priority over the miss check. Vertical bounce applies in the same frame as a horizontal event.
- SCORED:
  - The pause counter increments on each `frame_tick`.
  - When it reaches `PAUSE_FRAMES`, the ball recentres, the counter clears and the x-direction points toward the player who lost the point.
  - The next state is OVER if either score equals `WIN_SCORE`, otherwise IDLE.
- IDLE: `serve` high moves to PLAY.
- OVER: `serve` high clears both scores, recentres the ball and the paddles, and moves to IDLE. Scores saturate at `WIN_SCORE` and never wrap.
- Arithmetic is done at 11 bits so that subtraction underflow and overflow past `SCREEN_W` are detected before clamping.

## Timing
- Outputs are registered. A `frame_tick` in cycle N makes the new positions visible in cycle N+1, which is still inside vertical blank.
- `point` is high exactly in cycle N+1 of the frame that detects the miss.
- The IDLE→PLAY and OVER→IDLE transitions are visible the cycle after `serve` is sampled high.
- Reset takes effect immediately and asynchronously, including mid-frame or in the middle of a SCORED pause.

## Configuration
- `PONG_AI_EN` defined: the right paddle ignores `btn_r_up`/`btn_r_dn`.
  - Each frame it steps `PADDLE_SPEED` toward alignment of the paddle centre (`paddle_r_y + 32`) with the ball centre (`ball_y + 4`).
  - It holds when within `PADDLE_SPEED` of alignment.
  - The same clamp applies.
- `PONG_AI_EN` undefined: the right paddle is button-driven, identical to the left.

## Test plan
- Reset, then 3 frame ticks with `btn_l_up` held → `paddle_l_y` reads 196. Hold `btn_l_up` for 60 more ticks → clamps at 0.
- Serve with ball forced to (316, 2) moving up → after 1 tick `ball_y` = 0 and the ball moves down. After the next tick `ball_y` = 2.
- Left paddle at 208, ball moving left at x = 26, y = 230 → after 1 tick `ball_x` = 24 and the ball moves right. Score is unchanged.
- Left paddle at 0, ball moving left at y = 400 → `point` pulses once and `score_r` = 1. State stays SCORED for 60 ticks, then the ball is at (316, 236), the ball moves left and the state is IDLE.
- `score_l` = 8 and the right player misses → `score_l` = 9, the state is OVER after the pause, and paddles ignore buttons. `serve` → scores 0 and state IDLE.
- With `PONG_AI_EN`, right paddle at 208 and ball at y = 400 → after 1 tick `paddle_r_y` = 212 regardless of the `btn_r_*` inputs.

Source files
------------

// File: rtl/pong_motion_ctrl.sv
// -----------------------------------------------------------------------------
// pong_motion_ctrl
//
// Frame-rate game controller for the Pong display. On each frame_tick it steps
// both paddles and the ball, resolves wall and paddle bounces, detects missed
// balls, keeps score and sequences IDLE -> PLAY -> SCORED -> (IDLE | OVER).
// All outputs are registered and feed the box renderers in the pixel path.
//
// Build option:
//   PONG_AI_EN  defined   : right paddle tracks the ball automatically and
//                           ignores btn_r_up / btn_r_dn.
//               undefined : right paddle is button-driven like the left one.
//
// Ports:
//   pixel_clk     in   1   only clock
//   rst_n         in   1   asynchronous active-low reset
//   frame_tick    in   1   one-cycle pulse per frame (vertical blank start)
//   serve         in   1   level; IDLE->PLAY, OVER->IDLE (any cycle)
//   btn_l_up/dn   in   1   left paddle controls (already synchronised)
//   btn_r_up/dn   in   1   right paddle controls (already synchronised)
//   ball_x/y      out 10   ball top-left corner
//   paddle_l_y    out 10   left paddle top edge
//   paddle_r_y    out 10   right paddle top edge
//   score_l/r     out  4   points won, saturating at WIN_SCORE
//   game_state    out  2   0 IDLE, 1 PLAY, 2 SCORED, 3 OVER
//   point         out  1   one-cycle pulse when a point is awarded
// -----------------------------------------------------------------------------
module pong_motion_ctrl #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_L_X   = 16,
  parameter int PADDLE_R_X   = 616,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int PAUSE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic       btn_l_up,
  input  logic       btn_l_dn,
  input  logic       btn_r_up,
  input  logic       btn_r_dn,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle_l_y,
  output logic [9:0] paddle_r_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] game_state,
  output logic       point
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_SCORED = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(PAUSE_FRAMES + 1);

  // Centre / home positions
  localparam logic [9:0] BALL_X0   = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0] BALL_Y0   = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0] PADDLE_Y0 = 10'((SCREEN_H - PADDLE_H) / 2);

  // 11-bit signed constants so underflow below 0 and overflow past the
  // screen edge are visible before clamping.
  localparam logic signed [10:0] S_SCREEN_W = 11'(SCREEN_W);
  localparam logic signed [10:0] S_SCREEN_H = 11'(SCREEN_H);
  localparam logic signed [10:0] S_BSIZE    = 11'(BALL_SIZE);
  localparam logic signed [10:0] S_BSPD     = 11'(BALL_SPEED);
  localparam logic signed [10:0] S_PH       = 11'(PADDLE_H);
  localparam logic signed [10:0] S_PSPD     = 11'(PADDLE_SPEED);
  localparam logic signed [10:0] S_PMAX     = 11'(SCREEN_H - PADDLE_H);
  localparam logic signed [10:0] S_L_FACE   = 11'(PADDLE_L_X + PADDLE_W);
  localparam logic signed [10:0] S_R_FACE   = 11'(PADDLE_R_X);
  localparam logic signed [10:0] S_R_PARK   = 11'(PADDLE_R_X - BALL_SIZE);
  localparam logic signed [10:0] S_BY_MAX   = 11'(SCREEN_H - BALL_SIZE);
  localparam logic signed [10:0] S_BHALF    = 11'(BALL_SIZE / 2);
  localparam logic signed [10:0] S_PHALF    = 11'(PADDLE_H / 2);

  state_t           state;
  logic             dir_right;
  logic             dir_down;
  logic [CNT_W-1:0] pause_cnt;

  // ---------------------------------------------------------------------------
  // Saturation helpers
  // ---------------------------------------------------------------------------
  function automatic logic [9:0] clamp_paddle(input logic signed [10:0] y);
    if (y < 11'sd0)
      return 10'd0;
    else if (y > S_PMAX)
      return S_PMAX[9:0];
    else
      return y[9:0];
  endfunction

  function automatic logic [9:0] step_paddle(input logic [9:0] y,
                                             input logic       up,
                                             input logic       dn);
    logic signed [10:0] t;
    t = signed'({1'b0, y});
    if (up && !dn)
      t = t - S_PSPD;
    else if (dn && !up)
      t = t + S_PSPD;
    return clamp_paddle(t);
  endfunction

  function automatic logic [3:0] sat_score(input logic [3:0] s);
    if (s >= 4'(WIN_SCORE))
      return 4'(WIN_SCORE);
    else
      return s + 4'd1;
  endfunction

`ifdef PONG_AI_EN
  // Steer the paddle centre toward the ball centre; a dead band of one step
  // keeps it from dithering once aligned.
  function automatic logic [9:0] ai_paddle(input logic [9:0] y,
                                           input logic [9:0] by);
    logic signed [10:0] diff;
    diff = (signed'({1'b0, by}) + S_BHALF) - (signed'({1'b0, y}) + S_PHALF);
    if (diff > S_PSPD)
      return clamp_paddle(signed'({1'b0, y}) + S_PSPD);
    else if (diff < -S_PSPD)
      return clamp_paddle(signed'({1'b0, y}) - S_PSPD);
    else
      return y;
  endfunction

  logic btn_r_unused;
  assign btn_r_unused = btn_r_up ^ btn_r_dn;
`endif

  // ---------------------------------------------------------------------------
  // Next-frame candidates (all from pre-update register values)
  // ---------------------------------------------------------------------------
  logic signed [10:0] bx_s, by_s, pl_s, pr_s;
  logic signed [10:0] bx_nxt, by_nxt;
  logic               dir_right_nxt, dir_down_nxt;
  logic               l_overlap, r_overlap;
  logic               l_hit, r_hit, l_miss, r_miss;
  logic [9:0]         pl_nxt, pr_nxt;

  always_comb begin
    bx_s = signed'({1'b0, ball_x});
    by_s = signed'({1'b0, ball_y});
    pl_s = signed'({1'b0, paddle_l_y});
    pr_s = signed'({1'b0, paddle_r_y});

    pl_nxt = step_paddle(paddle_l_y, btn_l_up, btn_l_dn);
`ifdef PONG_AI_EN
    pr_nxt = ai_paddle(paddle_r_y, ball_y);
`else
    pr_nxt = step_paddle(paddle_r_y, btn_r_up, btn_r_dn);
`endif

    l_overlap = (by_s + S_BSIZE > pl_s) && (by_s < pl_s + S_PH);
    r_overlap = (by_s + S_BSIZE > pr_s) && (by_s < pr_s + S_PH);

    // A paddle hit wins over a miss on the same side.
    l_hit  = !dir_right && (bx_s - S_BSPD <= S_L_FACE) && l_overlap;
    r_hit  =  dir_right && (bx_s + S_BSIZE + S_BSPD >= S_R_FACE) && r_overlap;
    l_miss = !dir_right && (bx_s <= S_BSPD) && !l_hit;
    r_miss =  dir_right && (bx_s + S_BSIZE + S_BSPD >= S_SCREEN_W) && !r_hit;

    bx_nxt        = bx_s;
    dir_right_nxt = dir_right;
    if (l_hit) begin
      bx_nxt        = S_L_FACE;
      dir_right_nxt = 1'b1;
    end else if (r_hit) begin
      bx_nxt        = S_R_PARK;
      dir_right_nxt = 1'b0;
    end else if (dir_right) begin
      bx_nxt = bx_s + S_BSPD;
    end else begin
      bx_nxt = bx_s - S_BSPD;
    end

    by_nxt       = by_s;
    dir_down_nxt = dir_down;
    if (!dir_down) begin
      if (by_s <= S_BSPD) begin
        by_nxt       = 11'sd0;
        dir_down_nxt = 1'b1;
      end else begin
        by_nxt = by_s - S_BSPD;
      end
    end else begin
      if (by_s + S_BSIZE + S_BSPD >= S_SCREEN_H) begin
        by_nxt       = S_BY_MAX;
        dir_down_nxt = 1'b0;
      end else begin
        by_nxt = by_s + S_BSPD;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Game state and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ball_x     <= BALL_X0;
      ball_y     <= BALL_Y0;
      paddle_l_y <= PADDLE_Y0;
      paddle_r_y <= PADDLE_Y0;
      score_l    <= 4'd0;
      score_r    <= 4'd0;
      dir_right  <= 1'b1;
      dir_down   <= 1'b1;
      pause_cnt  <= '0;
      point      <= 1'b0;
    end else begin
      point <= 1'b0;

      if (frame_tick && state != ST_OVER) begin
        paddle_l_y <= pl_nxt;
        paddle_r_y <= pr_nxt;
      end

      unique case (state)
        ST_IDLE: begin
          if (serve)
            state <= ST_PLAY;
        end

        ST_PLAY: begin
          if (frame_tick) begin
            if (l_miss || r_miss) begin
              // Ball freezes where it is; x-direction is pinned toward the
              // side that lost, which is also the next serve direction.
              if (l_miss)
                score_r <= sat_score(score_r);
              else
                score_l <= sat_score(score_l);
              dir_right <= r_miss;
              point     <= 1'b1;
              pause_cnt <= '0;
              state     <= ST_SCORED;
            end else begin
              ball_x    <= bx_nxt[9:0];
              ball_y    <= by_nxt[9:0];
              dir_right <= dir_right_nxt;
              dir_down  <= dir_down_nxt;
            end
          end
        end

        ST_SCORED: begin
          if (frame_tick) begin
            if (pause_cnt == CNT_W'(PAUSE_FRAMES - 1)) begin
              ball_x    <= BALL_X0;
              ball_y    <= BALL_Y0;
              pause_cnt <= '0;
              if (score_l == 4'(WIN_SCORE) || score_r == 4'(WIN_SCORE))
                state <= ST_OVER;
              else
                state <= ST_IDLE;
            end else begin
              pause_cnt <= pause_cnt + 1'b1;
            end
          end
        end

        ST_OVER: begin
          if (serve) begin
            score_l    <= 4'd0;
            score_r    <= 4'd0;
            ball_x     <= BALL_X0;
            ball_y     <= BALL_Y0;
            paddle_l_y <= PADDLE_Y0;
            paddle_r_y <= PADDLE_Y0;
            state      <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_pong_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_motion_ctrl
//
// Scoreboard bench. The stimulus process drives inputs on the falling edge,
// advances a behavioural game model by one clock and queues the outputs the
// DUT must show after the next rising edge. An independent monitor pops one
// entry per clock and compares it against the registered outputs.
// -----------------------------------------------------------------------------
module tb_pong_motion_ctrl;

  logic       pixel_clk = 1'b0;
  logic       rst_n     = 1'b1;
  logic       frame_tick, serve;
  logic       btn_l_up, btn_l_dn, btn_r_up, btn_r_dn;
  logic [9:0] ball_x, ball_y, paddle_l_y, paddle_r_y;
  logic [3:0] score_l, score_r;
  logic [1:0] game_state;
  logic       point;

  pong_motion_ctrl dut (
    .pixel_clk  (pixel_clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .serve      (serve),
    .btn_l_up   (btn_l_up),
    .btn_l_dn   (btn_l_dn),
    .btn_r_up   (btn_r_up),
    .btn_r_dn   (btn_r_dn),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .paddle_l_y (paddle_l_y),
    .paddle_r_y (paddle_r_y),
    .score_l    (score_l),
    .score_r    (score_r),
    .game_state (game_state),
    .point      (point)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct packed {
    logic [9:0] bx;
    logic [9:0] by;
    logic [9:0] pl;
    logic [9:0] pr;
    logic [3:0] sl;
    logic [3:0] sr;
    logic [1:0] st;
    logic       pt;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Game model: plain integers, directions as +1 / -1.
  localparam int IDLE = 0, PLAY = 1, SCORED = 2, OVER = 3;
  int m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_st, m_cnt, m_dx, m_dy, m_pt;
  bit m_loser_left;
  int n_points, n_overs;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    m_bx = 316; m_by = 236; m_pl = 208; m_pr = 208;
    m_sl = 0;   m_sr = 0;   m_st = IDLE; m_cnt = 0;
    m_dx = 1;   m_dy = 1;   m_pt = 0;    m_loser_left = 1'b0;
  endtask

  task automatic model_step(input bit rst, input bit tick, input bit srv,
                            input bit lu, input bit ld, input bit ru, input bit rd);
    int  pre_by, pre_pl, pre_pr, err, ny;
    bit  lhit, rhit, lmiss, rmiss;
    m_pt = 0;
    if (rst) begin
      model_reset();
      return;
    end
    pre_by = m_by; pre_pl = m_pl; pre_pr = m_pr;

    if (tick && m_st != OVER) begin
      m_pl = clampi(m_pl + 4 * (int'(ld) - int'(lu)), 0, 416);
`ifdef PONG_AI_EN
      err = (pre_by + 4) - (pre_pr + 32);
      if (err > 4)       m_pr = clampi(m_pr + 4, 0, 416);
      else if (err < -4) m_pr = clampi(m_pr - 4, 0, 416);
`else
      err = 0;
      m_pr = clampi(m_pr + 4 * (int'(rd) - int'(ru)), 0, 416);
`endif
    end

    case (m_st)
      IDLE: if (srv) m_st = PLAY;
      PLAY: if (tick) begin
        lhit  = (m_dx < 0) && (m_bx - 2 <= 24) &&
                (pre_by + 8 > pre_pl) && (pre_by < pre_pl + 64);
        rhit  = (m_dx > 0) && (m_bx + 10 >= 616) &&
                (pre_by + 8 > pre_pr) && (pre_by < pre_pr + 64);
        lmiss = (m_dx < 0) && !lhit && (m_bx <= 2);
        rmiss = (m_dx > 0) && !rhit && (m_bx + 10 >= 640);
        if (lmiss || rmiss) begin
          if (lmiss) m_sr = (m_sr + 1 > 9) ? 9 : m_sr + 1;
          else       m_sl = (m_sl + 1 > 9) ? 9 : m_sl + 1;
          m_loser_left = lmiss;
          m_pt  = 1;
          m_cnt = 0;
          m_st  = SCORED;
          n_points++;
        end else begin
          if (lhit)      begin m_bx = 24;  m_dx = 1;  end
          else if (rhit) begin m_bx = 608; m_dx = -1; end
          else           m_bx = m_bx + 2 * m_dx;
          ny = m_by + 2 * m_dy;
          if (ny <= 0)        begin m_by = 0;   m_dy = 1;  end
          else if (ny >= 472) begin m_by = 472; m_dy = -1; end
          else                m_by = ny;
        end
      end
      SCORED: if (tick) begin
        m_cnt++;
        if (m_cnt == 60) begin
          m_bx = 316; m_by = 236; m_cnt = 0;
          m_dx = m_loser_left ? -1 : 1;
          if (m_sl == 9 || m_sr == 9) begin m_st = OVER; n_overs++; end
          else m_st = IDLE;
        end
      end
      OVER: if (srv) begin
        m_sl = 0; m_sr = 0; m_bx = 316; m_by = 236;
        m_pl = 208; m_pr = 208; m_st = IDLE;
      end
      default: ;
    endcase
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.bx = 10'(m_bx); o.by = 10'(m_by); o.pl = 10'(m_pl); o.pr = 10'(m_pr);
    o.sl = 4'(m_sl);  o.sr = 4'(m_sr);  o.st = 2'(m_st);  o.pt = 1'(m_pt);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.bx = ball_x;  o.by = ball_y;  o.pl = paddle_l_y; o.pr = paddle_r_y;
    o.sl = score_l; o.sr = score_r; o.st = game_state; o.pt = point;
    return o;
  endfunction

  task automatic compare(input string name, input obs_t act, input obs_t req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s t=%0t got bx=%0d by=%0d pl=%0d pr=%0d sl=%0d sr=%0d st=%0d pt=%0d want bx=%0d by=%0d pl=%0d pr=%0d sl=%0d sr=%0d st=%0d pt=%0d",
               name, $time, act.bx, act.by, act.pl, act.pr, act.sl, act.sr, act.st, act.pt,
               req.bx, req.by, req.pl, req.pr, req.sl, req.sr, req.st, req.pt);
    end
  endtask

  task automatic check_reset_now(input string name);
    obs_t r;
    r.bx = 10'd316; r.by = 10'd236; r.pl = 10'd208; r.pr = 10'd208;
    r.sl = 4'd0;    r.sr = 4'd0;    r.st = 2'd0;    r.pt = 1'b0;
    compare(name, dut_obs(), r);
  endtask

  // Monitor: one expected entry per rising edge, sampled 1 time unit later.
  always begin
    obs_t e;
    @(posedge pixel_clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compare("outputs", dut_obs(), e);
    end
  end

  localparam int DIRECTED = 140;
  localparam int RST_AT   = 40000;
  localparam int N_CYC    = 52000;

  initial begin
    int gap;
    bit r, t, s, lu, ld, ru, rd;
    frame_tick = 1'b0; serve = 1'b0;
    btn_l_up = 1'b0; btn_l_dn = 1'b0; btn_r_up = 1'b0; btn_r_dn = 1'b0;
    n_points = 0; n_overs = 0;
    model_reset();

    #1 rst_n = 1'b0;
    #1 check_reset_now("reset_state");
    gap = 0;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge pixel_clk);
      r = !(cyc < 3 || (cyc >= RST_AT && cyc < RST_AT + 3));
      if (cyc < DIRECTED) begin
        // Idle with left-up held: 208 -> 196 after 3 ticks, then clamps at 0.
        t  = (cyc >= 3) && (cyc % 2 == 1);
        s  = 1'b0;
        lu = 1'b1; ld = 1'b0; ru = 1'b0; rd = 1'b0;
      end else begin
        if (gap == 0) begin
          t   = 1'b1;
          gap = $urandom_range(0, 3);
        end else begin
          t = 1'b0;
          gap--;
        end
        s  = ($urandom_range(0, 7) == 0);
        lu = $urandom_range(0, 1); ld = $urandom_range(0, 1);
        ru = $urandom_range(0, 1); rd = $urandom_range(0, 1);
      end
      frame_tick = t; serve = s;
      btn_l_up = lu; btn_l_dn = ld; btn_r_up = ru; btn_r_dn = rd;
      rst_n = r;
      model_step(!r, t, s, lu, ld, ru, rd);
      exp_q.push_back(model_obs());
      if (cyc == RST_AT) begin
        // Reset must act before the next rising edge.
        #2 check_reset_now("async_reset");
      end
    end

    @(negedge pixel_clk);
    frame_tick = 1'b0; serve = 1'b0;
    repeat (3) @(negedge pixel_clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
